apb_slave_regfile: RTL and testbench

APB completer that sits on one Pselx line of the AHB-to-APB bridge and answers its setup/access transfers.
- Holds a small word-addressed register file.
- Returns read data on Prdata during the access phase.
- Tracks APB phase with a 3-state FSM and counts completed transfers.
- Gives bridge benches and top-level sims a real slave model with cycle-checkable behaviour.

---
 rtl/apb_slave_pkg.sv | 22 ++
 rtl/apb_prot_checker.sv | 51 +++++
 rtl/apb_slave_regfile.sv | 134 +++++++++++++
 tb/tb_apb_slave_regfile.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_pkg.sv
// Shared types and bus constants for the APB register-file completer.
package apb_slave_pkg;

    localparam int APB_DW     = 32;
    localparam int APB_AW     = 32;
    localparam int NUM_SLAVES = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_phase_e;

    // Bus phase seen in the current cycle; Penable without a select counts as IDLE.
    function automatic apb_phase_e decode_phase(input logic sel, input logic enable);
        if (!sel) begin
            return IDLE;
        end
        return enable ? ACCESS : SETUP;
    endfunction

endpackage

// File: rtl/apb_prot_checker.sv
// Sticky APB protocol-violation monitor for one completer.
// Only instantiated when APB_SLV_PROT_CHECK_EN is defined.
module apb_prot_checker
    import apb_slave_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            sel_i,
    input  logic            penable_i,
    input  apb_phase_e      phase_i,
    input  apb_phase_e      state_i,
    input  logic [AW-1:0]   idx_i,
    input  logic [AW-1:0]   latched_idx_i,
    input  logic            write_i,
    input  logic            latched_write_i,
    output logic            prot_err_o
);

    logic violation;
    logic prot_err_q;
    logic prot_err_d;

    always_comb begin
        violation = 1'b0;
        if (phase_i == ACCESS) begin
            if (state_i != SETUP || idx_i != latched_idx_i || write_i != latched_write_i) begin
                violation = 1'b1;
            end
        end
        if (phase_i == SETUP && state_i == SETUP) begin
            violation = 1'b1;
        end
        if (penable_i && !sel_i) begin
            violation = 1'b1;
        end
        prot_err_d = prot_err_q | violation;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prot_err_q <= 1'b0;
        end else begin
            prot_err_q <= prot_err_d;
        end
    end

    assign prot_err_o = prot_err_q;

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a word-addressed register file, registered read data and
// saturating transfer counters. Define APB_SLV_PROT_CHECK_EN to enable prot_err.
module apb_slave_regfile
    import apb_slave_pkg::*;
#(
    parameter int SEL_IDX = 0,
    parameter int DEPTH   = 16,
    parameter int AW      = $clog2(DEPTH),
    parameter int CNT_W   = 16
) (
    input  logic                  Hclk,
    input  logic                  Hreset,
    input  logic [NUM_SLAVES-1:0] Pselx,
    input  logic                  Penable,
    input  logic                  Pwrite,
    input  logic [APB_AW-1:0]     Paddr,
    input  logic [APB_DW-1:0]     Pwdata,
    output logic [APB_DW-1:0]     Prdata,
    output logic [CNT_W-1:0]      wr_count,
    output logic [CNT_W-1:0]      rd_count,
    output logic                  prot_err
);

    logic              sel;
    apb_phase_e        phase_d;
    apb_phase_e        state_q;
    logic [AW-1:0]     paddr_idx;
    logic [AW-1:0]     idx_q;
    logic              wr_q;
    logic [APB_DW-1:0] mem_q [DEPTH];
    logic [APB_DW-1:0] prdata_q;
    logic [CNT_W-1:0]  wr_count_q;
    logic [CNT_W-1:0]  wr_count_d;
    logic [CNT_W-1:0]  rd_count_q;
    logic [CNT_W-1:0]  rd_count_d;
    logic              setup_fire;
    logic              access_ok;
    logic              commit_wr;
    logic              commit_rd;
    logic              unused_bits;

    assign sel         = Pselx[SEL_IDX];
    assign paddr_idx   = Paddr[AW+1:2];
    assign unused_bits = ^{Pselx, Paddr[APB_AW-1:AW+2], Paddr[1:0]};

    always_comb begin
        phase_d = decode_phase(sel, Penable);
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_q <= IDLE;
        end else begin
            state_q <= phase_d;
        end
    end

    // A transfer commits only from SETUP and only if address/direction held stable.
    assign setup_fire = (phase_d == SETUP);
    assign access_ok  = (phase_d == ACCESS) && (state_q == SETUP)
                        && (paddr_idx == idx_q) && (Pwrite == wr_q);
    assign commit_wr  = access_ok && wr_q;
    assign commit_rd  = access_ok && !wr_q;

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            idx_q    <= '0;
            wr_q     <= 1'b0;
            prdata_q <= '0;
        end else if (setup_fire) begin
            idx_q <= paddr_idx;
            wr_q  <= Pwrite;
            if (!Pwrite) begin
                prdata_q <= mem_q[paddr_idx];
            end
        end
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit_wr) begin
            mem_q[idx_q] <= Pwdata;
        end
    end

    always_comb begin
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        if (commit_wr && wr_count_q != '1) begin
            wr_count_d = wr_count_q + 1'b1;
        end
        if (commit_rd && rd_count_q != '1) begin
            rd_count_d = rd_count_q + 1'b1;
        end
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
        end
    end

    assign Prdata   = prdata_q;
    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;

`ifdef APB_SLV_PROT_CHECK_EN
    apb_prot_checker #(
        .AW(AW)
    ) u_prot_checker (
        .clk_i           (Hclk),
        .rst_i           (Hreset),
        .sel_i           (sel),
        .penable_i       (Penable),
        .phase_i         (phase_d),
        .state_i         (state_q),
        .idx_i           (paddr_idx),
        .latched_idx_i   (idx_q),
        .write_i         (Pwrite),
        .latched_write_i (wr_q),
        .prot_err_o      (prot_err)
    );
`else
    assign prot_err = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Randomized transaction-level bench: a default-width instance and a 3-bit-counter
// instance share one APB bus and are both checked against an array-based model.
module tb_apb_slave_regfile;

    localparam int DEPTH = 16;
    localparam int SAT_W = 3;
`ifdef APB_SLV_PROT_CHECK_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic              Hclk = 1'b0;
    logic              Hreset;
    logic [2:0]        Pselx;
    logic              Penable;
    logic              Pwrite;
    logic [31:0]       Paddr;
    logic [31:0]       Pwdata;
    logic [31:0]       prdata_a, prdata_b;
    logic [15:0]       wr_a, rd_a;
    logic [SAT_W-1:0]  wr_b, rd_b;
    logic              perr_a, perr_b;

    always #5 Hclk = ~Hclk;

    apb_slave_regfile #(.SEL_IDX(0), .DEPTH(DEPTH), .CNT_W(16)) u_dut (
        .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable),
        .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata_a),
        .wr_count(wr_a), .rd_count(rd_a), .prot_err(perr_a)
    );

    apb_slave_regfile #(.SEL_IDX(0), .DEPTH(DEPTH), .CNT_W(SAT_W)) u_sat (
        .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable),
        .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata_b),
        .wr_count(wr_b), .rd_count(rd_b), .prot_err(perr_b)
    );

    // Reference model: register contents, last read data, unbounded counts, sticky flag.
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] ref_prdata;
    int          ref_wr;
    int          ref_rd;
    logic        ref_prot;
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic int idx_of(input logic [31:0] addr);
        return int'((addr >> 2) % DEPTH);
    endfunction

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "/prdata"},   prdata_a, ref_prdata);
        check_eq({tag, "/prdata_s"}, prdata_b, ref_prdata);
        check_eq({tag, "/wr_cnt"},   32'(wr_a), 32'(sat(ref_wr, 16)));
        check_eq({tag, "/rd_cnt"},   32'(rd_a), 32'(sat(ref_rd, 16)));
        check_eq({tag, "/wr_sat"},   32'(wr_b), 32'(sat(ref_wr, SAT_W)));
        check_eq({tag, "/rd_sat"},   32'(rd_b), 32'(sat(ref_rd, SAT_W)));
        check_eq({tag, "/prot"},     32'(perr_a), 32'(ref_prot & PROT_EN));
        check_eq({tag, "/prot_s"},   32'(perr_b), 32'(ref_prot & PROT_EN));
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_prdata = '0;
        ref_wr     = 0;
        ref_rd     = 0;
        ref_prot   = 1'b0;
    endtask

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic drive(input logic [2:0] sel, input logic en, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data);
        Pselx = sel; Penable = en; Pwrite = wr; Paddr = addr; Pwdata = data;
    endtask

    task automatic go_idle();
        drive(3'b000, 1'b0, 1'b0, $urandom, $urandom);
        tick();
    endtask

    task automatic apb_write(input logic [2:0] sel, input logic [31:0] addr, input logic [31:0] data);
        $display("[TB] write sel=%b addr=%08h data=%08h", sel, addr, data);
        drive(sel, 1'b0, 1'b1, addr, data); tick();
        drive(sel, 1'b1, 1'b1, addr, data); tick();
        if (sel[0]) begin
            ref_mem[idx_of(addr)] = data;
            ref_wr++;
        end else begin
            ref_prot = 1'b1;
        end
        check_state("write");
    endtask

    task automatic apb_read(input logic [2:0] sel, input logic [31:0] addr);
        $display("[TB] read  sel=%b addr=%08h", sel, addr);
        drive(sel, 1'b0, 1'b0, addr, $urandom); tick();
        if (sel[0]) ref_prdata = ref_mem[idx_of(addr)];
        check_eq("read/access_data", prdata_a, ref_prdata);
        drive(sel, 1'b1, 1'b0, addr, $urandom); tick();
        if (sel[0]) ref_rd++;
        else ref_prot = 1'b1;
        check_state("read");
    endtask

    task automatic bad_no_setup(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        $display("[TB] access-without-setup wr=%b addr=%08h", wr, addr);
        drive(3'b001, 1'b1, wr, addr, data); tick();
        ref_prot = 1'b1;
        check_state("no_setup");
    endtask

    task automatic bad_change(input logic wr, input logic [31:0] addr, input logic [31:0] addr2,
                              input logic flip_wr, input logic [31:0] data);
        $display("[TB] changed-access wr=%b addr=%08h->%08h flip=%b", wr, addr, addr2, flip_wr);
        drive(3'b001, 1'b0, wr, addr, data); tick();
        if (!wr) ref_prdata = ref_mem[idx_of(addr)];
        drive(3'b001, 1'b1, flip_wr ? ~wr : wr, addr2, data); tick();
        ref_prot = 1'b1;
        check_state("changed");
    endtask

    task automatic setup_setup(input logic wr, input logic [31:0] addr_a, input logic [31:0] addr_b,
                               input logic [31:0] data);
        $display("[TB] double-setup wr=%b addr=%08h,%08h data=%08h", wr, addr_a, addr_b, data);
        drive(3'b001, 1'b0, wr, addr_a, data); tick();
        drive(3'b001, 1'b0, wr, addr_b, data); tick();
        if (!wr) ref_prdata = ref_mem[idx_of(addr_b)];
        drive(3'b001, 1'b1, wr, addr_b, data); tick();
        ref_prot = 1'b1;
        if (wr) begin
            ref_mem[idx_of(addr_b)] = data;
            ref_wr++;
        end else begin
            ref_rd++;
        end
        check_state("dbl_setup");
    endtask

    logic [2:0]  sel_tab [6];
    int          op;
    logic [31:0] ra, rb;

    initial begin
        sel_tab = '{3'b001, 3'b001, 3'b001, 3'b011, 3'b010, 3'b100};
        Hreset = 1'b1;
        drive(3'b000, 1'b0, 1'b0, '0, '0);
        model_reset();
        tick(); tick();
        Hreset = 1'b0;
        check_state("reset");
        go_idle();

        apb_write(3'b001, 32'h8000_0004, 32'hA5A5_5A5A);
        check_eq("first_wr_count", 32'(wr_a), 32'd1);
        apb_read(3'b001, 32'h8000_0004);
        check_eq("readback", prdata_a, 32'hA5A5_5A5A);
        check_eq("first_rd_count", 32'(rd_a), 32'd1);

        apb_write(3'b001, 32'h8000_0000, 32'h1111_1111);
        apb_write(3'b001, 32'h8000_003C, 32'h2222_2222);
        apb_read(3'b001, 32'h8000_0040);
        check_eq("wrap_read", prdata_a, 32'h1111_1111);

        apb_write(3'b010, 32'h8000_0004, 32'hFFFF_0000);
        apb_read(3'b010, 32'h8000_0004);
        check_eq("other_slave_wr", 32'(wr_a), 32'd3);
        apb_read(3'b001, 32'h8000_0004);
        check_eq("other_slave_reg", prdata_a, 32'hA5A5_5A5A);

        go_idle();
        bad_no_setup(1'b1, 32'h0000_0004, 32'hFFFF_FFFF);
        bad_change(1'b1, 32'h0000_0004, 32'h0000_0008, 1'b0, 32'h5555_5555);
        apb_read(3'b001, 32'h0000_0008);
        apb_read(3'b001, 32'h0000_0004);
        check_eq("no_write_on_bad", prdata_a, 32'hA5A5_5A5A);
        go_idle(); go_idle();
        check_eq("prot_sticky", 32'(perr_a), 32'(PROT_EN));

        $display("[TB] reset during write access");
        drive(3'b001, 1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF); tick();
        drive(3'b001, 1'b1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF); #2;
        Hreset = 1'b1;
        tick();
        drive(3'b000, 1'b0, 1'b0, '0, '0);
        Hreset = 1'b0;
        model_reset();
        check_state("mid_reset");
        go_idle();
        apb_read(3'b001, 32'h0000_0008);
        check_eq("after_reset_read", prdata_a, 32'h0);

        for (int t = 0; t < 300; t++) begin
            op = $urandom_range(0, 11);
            ra = $urandom;
            rb = ra ^ (32'($urandom_range(1, DEPTH - 1)) << 2);
            if ($urandom_range(0, 3) == 0) go_idle();
            case (op)
                0, 1, 2, 3: apb_write(sel_tab[$urandom_range(0, 5)], ra, $urandom);
                4, 5, 6, 7: apb_read(sel_tab[$urandom_range(0, 5)], ra);
                8:          bad_no_setup(1'($urandom), ra, $urandom);
                9:          bad_change(1'($urandom), ra, rb, 1'b0, $urandom);
                10:         bad_change(1'($urandom), ra, ra, 1'b1, $urandom);
                default:    setup_setup(1'($urandom), ra, rb, $urandom);
            endcase
        end

        go_idle();
        for (int i = 0; i < DEPTH; i++) begin
            apb_read(3'b001, 32'(i) << 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
